mux_chan_scanner: RTL
=====================

// Module: mux_chan_scanner
// PURPOSE
//  Upstream sequencer for the 4:1 channel mux: drives the mux's 2-bit select, steps
//  through the enabled channels, holds each for a programmable dwell time, and samples
//  the returned mux output. After the scan it presents one 4-bit frame, one bit per
//  channel, to the consumer over a valid/ready handshake.
// PARAMETERS
//  DWELL   4   cycles each enabled channel is selected before sampling; legal 1..255
//  CNT_W   8   width of the dwell counter; must satisfy DWELL <= 2**CNT_W-1
// PORTS
//  clk          in   1  single clock; all state updates on rising edge
//  rst          in   1  asynchronous, active-high reset
//  start        in   1  scan request; accepted only in IDLE
//  en_mask      in   4  channel enables; bit i = channel i; sampled when start is accepted
//  mux_out      in   1  output of the downstream 4:1 mux (combinational function of sel)
//  sel          out  2  select to the 4:1 mux; registered
//  busy         out  1  high in SCAN and DONE
//  frame        out  4  captured samples; bit i = channel i; disabled channels read 0
//  frame_valid  out  1  frame is stable and must be consumed
//  frame_ready  in   1  consumer accepts frame
// BEHAVIOUR
//  Reset: state=IDLE, sel=2'b00, busy=0, frame=4'h0, frame_valid=0, counter=0, mask=0.
//   Reset asserted mid-scan or in DONE aborts immediately; the partial frame is discarded.
//  FSM IDLE -> SCAN -> DONE -> IDLE.
//  IDLE: On start=1 with en_mask!=0, latch en_mask, clear frame, set sel = lowest set
//   bit, set counter=DWELL-1, and go to SCAN. start with en_mask==0 is ignored and
//   the block stays in IDLE.
//  SCAN: counter!=0 -> decrement it; sel holds.
//   counter==0 -> frame[sel] <= mux_out at this edge.
//    If the latched mask has a set bit above sel, sel <= the next such bit and
//    counter <= DWELL-1. Otherwise go to DONE and set frame_valid=1; sel holds.
//   The channel order is always ascending; there is no wrap-around within a frame.
//  DONE: frame and sel hold. On frame_valid & frame_ready at an edge, clear
//   frame_valid and return to IDLE. frame is retained until the next accepted start.
//  start in SCAN or DONE is ignored; it is not queued. en_mask changes after
//   acceptance are ignored.
//  Timing: start accepted at edge E0. For k enabled channels, the j-th sample
//   (j=1..k) is taken at edge E0+j*DWELL, and frame_valid=1 after edge E0+k*DWELL.
//   A new start is accepted no earlier than the edge after the handshake.
//  Each sel value is stable for DWELL cycles before its sample, which covers mux settling.
// STRUCTURE
//  Shared package: FSM state encoding (IDLE=2'd0, SCAN=2'd1, DONE=2'd2) and
//   constant NUM_CH=4.
//  Sub-module next_chan_find: combinational. Inputs mask[3:0] and cur[1:0]; outputs
//   nxt[1:0] and found. With a separate first-mode input, it also returns the lowest
//   set bit for the IDLE->SCAN load.
//  The top level holds the FSM, the dwell counter, the frame register, and the handshake.
// TESTING
//  1 DWELL=4, en_mask=4'b1111, mux inputs {in3..in0}=4'b1010, start at E0 -> sel
//    0,1,2,3 for 4 cycles each; frame_valid after E0+16; frame=4'b1010.
//  2 en_mask=4'b0101, inputs=4'b1111 -> sel visits only 0 then 2; frame=4'b0101 at
//    E0+8; channels 1 and 3 read 0.
//  3 en_mask=4'b0000 with start -> remains IDLE, busy=0, no frame_valid; then
//    en_mask=4'b1000 -> sel=3, frame=4'b1000 (in3=1) after DWELL cycles.
//  4 frame_ready=0 for 10 cycles after frame_valid -> frame, frame_valid, sel held;
//    start pulses ignored; raise ready -> valid drops next edge, IDLE.
//  5 rst pulsed at E0+6 of a full scan -> all outputs reset values on the async edge;
//    a new start after release gives a fresh correct frame.
//  6 DWELL=1, en_mask=4'b1111 -> sel changes every cycle; frame_valid after E0+4;
//    frame_ready tied high -> valid is high for exactly 1 cycle.

Source files
------------

// File: rtl/mux_chan_scanner_pkg.sv
// Shared definitions for the channel-mux scanner.
// Holds the FSM state encoding and the channel count.
package mux_chan_scanner_pkg;

    localparam int NUM_CH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mux_chan_scanner_next_chan_find.sv
// next_chan_find: combinational search of a channel mask.
// Ports: mask (enables), cur (current channel), first (1 = lowest set bit,
//        0 = lowest set bit strictly above cur); nxt (result), found.
module next_chan_find
    import mux_chan_scanner_pkg::*;
(
    input  logic [NUM_CH-1:0] mask,
    input  logic [1:0]        cur,
    input  logic              first,
    output logic [1:0]        nxt,
    output logic              found
);

    always_comb begin
        nxt   = 2'd0;
        found = 1'b0;
        // Walk downward so the last hit is the lowest qualifying bit.
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask[i] && (first || (i > int'(cur)))) begin
                nxt   = 2'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_chan_scanner.sv
// mux_chan_scanner: steps a 4:1 mux select through enabled channels,
// dwells DWELL cycles on each, samples mux_out, and hands the 4-bit frame
// to a consumer over valid/ready.
// Ports: clk, rst (async high), start, en_mask, mux_out in;
//        sel, busy, frame, frame_valid out; frame_ready in.
module mux_chan_scanner
    import mux_chan_scanner_pkg::*;
#(
    parameter int DWELL = 4,
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [NUM_CH-1:0] en_mask,
    input  logic              mux_out,
    output logic [1:0]        sel,
    output logic              busy,
    output logic [NUM_CH-1:0] frame,
    output logic              frame_valid,
    input  logic              frame_ready
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DWELL - 1);

    state_t              state_q, state_d;
    logic [1:0]          sel_q, sel_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [NUM_CH-1:0]   frame_q, frame_d;
    logic [NUM_CH-1:0]   mask_q, mask_d;
    logic                valid_q, valid_d;
    logic                busy_q, busy_d;

    logic                find_first;
    logic [NUM_CH-1:0]   find_mask;
    logic [1:0]          find_nxt;
    logic                find_found;

    // In IDLE the finder looks at the live enables for the first channel;
    // during the scan it looks above sel in the latched mask.
    assign find_first = (state_q == IDLE);
    assign find_mask  = (state_q == IDLE) ? en_mask : mask_q;

    next_chan_find u_find (
        .mask  (find_mask),
        .cur   (sel_q),
        .first (find_first),
        .nxt   (find_nxt),
        .found (find_found)
    );

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        frame_d = frame_q;
        mask_d  = mask_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        unique case (state_q)
            IDLE: begin
                if (start && (en_mask != '0)) begin
                    mask_d  = en_mask;
                    frame_d = '0;
                    sel_d   = find_nxt;
                    cnt_d   = CNT_LOAD;
                    state_d = SCAN;
                    busy_d  = 1'b1;
                end
            end
            SCAN: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    frame_d[sel_q] = mux_out;
                    if (find_found) begin
                        sel_d = find_nxt;
                        cnt_d = CNT_LOAD;
                    end else begin
                        state_d = DONE;
                        valid_d = 1'b1;
                    end
                end
            end
            DONE: begin
                if (valid_q && frame_ready) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= 2'b00;
            cnt_q   <= '0;
            frame_q <= '0;
            mask_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            frame_q <= frame_d;
            mask_q  <= mask_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

    assign sel         = sel_q;
    assign busy        = busy_q;
    assign frame       = frame_q;
    assign frame_valid = valid_q;

endmodule
